config_scheduler: RTL and testbench

Sequences NanEye sensor configuration uploads in the 48 MHz system-clock domain. Holds a host-written 24-bit configuration word and launches the configuration transmitter only when the decoder opens a configuration window. It then supervises completion with a timeout and a bounded retry count. It sits between host register logic and the configuration transmitter, and its window input comes from the RX decoder.

---
 rtl/cfg_sched_pkg.sv | 15 +
 rtl/cfg_sync_edge.sv | 30 +++
 rtl/config_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_config_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_sched_pkg.sv
// rtl/cfg_sched_pkg.sv - shared types and widths for the configuration upload scheduler
package cfg_sched_pkg;

  localparam int CFG_WORD_W = 24;
  localparam int SENT_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_END,
    RETRY,
    ARMED
  } state_e;

endpackage

// File: rtl/cfg_sync_edge.sv
// rtl/cfg_sync_edge.sv - two-flop synchronizer followed by a registered rising-edge pulse
module cfg_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/config_scheduler.sv
// rtl/config_scheduler.sv - launches host config words into decoder windows, with timeout and retry
// Optional periodic re-send of the last good word when CFG_SCHED_REFRESH_EN is defined.
module config_scheduler
  import cfg_sched_pkg::*;
#(
  parameter int G_CFG_W           = CFG_WORD_W,
  parameter int G_TIMEOUT_CYCLES  = 4096,
  parameter int G_MAX_RETRY       = 3,
  parameter int G_REFRESH_WINDOWS = 16
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  HOST_WR,
  input  logic [G_CFG_W-1:0]    HOST_DATA,
  input  logic                  CONFIG_EN,
  input  logic                  TX_END,
  output logic                  TX_START,
  output logic [G_CFG_W-1:0]    TX_WORD,
  output logic                  BUSY,
  output logic                  PENDING,
  output logic                  CFG_ERROR,
  output logic [SENT_CNT_W-1:0] SENT_CNT
);

  localparam int TMR_W = $clog2(G_TIMEOUT_CYCLES + 1);
  localparam int RTY_W = (G_MAX_RETRY > 0) ? $clog2(G_MAX_RETRY + 1) : 1;

  state_e                state_q, state_d;
  logic [G_CFG_W-1:0]    word_q, word_d;
  logic [G_CFG_W-1:0]    pword_q, pword_d;
  logic                  pend_q, pend_d;
  logic [RTY_W-1:0]      retry_q, retry_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  err_q, err_d;
  logic [SENT_CNT_W-1:0] sent_q, sent_d;
  logic                  tx_start_q;
  logic                  busy_q;
  logic                  win_open;

`ifdef CFG_SCHED_REFRESH_EN
  localparam int REF_W = $clog2(G_REFRESH_WINDOWS + 1);

  logic [G_CFG_W-1:0] good_q, good_d;
  logic               good_vld_q, good_vld_d;
  logic [REF_W-1:0]   ref_q, ref_d;
`else
  localparam int unused_refresh_windows = G_REFRESH_WINDOWS;
`endif

  cfg_sync_edge u_win_sync (
    .clk_i   (CLOCK),
    .rst_i   (RESET),
    .async_i (CONFIG_EN),
    .pulse_o (win_open)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pword_d = pword_q;
    pend_d  = pend_q;
    retry_d = retry_q;
    timer_d = timer_q;
    err_d   = err_q;
    sent_d  = sent_q;
`ifdef CFG_SCHED_REFRESH_EN
    good_d     = good_q;
    good_vld_d = good_vld_q;
    ref_d      = HOST_WR ? '0 : ref_q;
`endif

    // The host register never stalls; launches below may consume the word in the same cycle.
    if (HOST_WR) begin
      pword_d = HOST_DATA;
      pend_d  = 1'b1;
      err_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (win_open && (pend_q || HOST_WR)) begin
          word_d  = HOST_WR ? HOST_DATA : pword_q;
          pend_d  = 1'b0;
          retry_d = '0;
          state_d = SEND;
        end
`ifdef CFG_SCHED_REFRESH_EN
        else if (win_open && good_vld_q) begin
          if (ref_q == REF_W'(G_REFRESH_WINDOWS - 1)) begin
            word_d  = good_q;
            retry_d = '0;
            ref_d   = '0;
            state_d = SEND;
          end else begin
            ref_d = ref_q + REF_W'(1);
          end
        end
`endif
      end
      SEND: begin
        timer_d = TMR_W'(G_TIMEOUT_CYCLES);
        state_d = WAIT_END;
      end
      WAIT_END: begin
        // Completion is checked before expiry so a last-cycle TX_END still counts.
        if (TX_END) begin
          sent_d  = sent_q + SENT_CNT_W'(1);
          state_d = IDLE;
`ifdef CFG_SCHED_REFRESH_EN
          good_d     = word_q;
          good_vld_d = 1'b1;
`endif
        end else begin
          timer_d = timer_q - TMR_W'(1);
          if (timer_d == '0) begin
            state_d = RETRY;
          end
        end
      end
      RETRY: begin
        if (pend_q || HOST_WR) begin
          state_d = IDLE;
        end else if (retry_q < RTY_W'(G_MAX_RETRY)) begin
          retry_d = retry_q + RTY_W'(1);
          state_d = ARMED;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (HOST_WR) begin
          state_d = IDLE;
        end else if (win_open) begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      word_q     <= '0;
      pword_q    <= '0;
      pend_q     <= 1'b0;
      retry_q    <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      sent_q     <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      pword_q    <= pword_d;
      pend_q     <= pend_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      sent_q     <= sent_d;
      tx_start_q <= (state_d == SEND);
      busy_q     <= (state_d == SEND) || (state_d == WAIT_END);
    end
  end

`ifdef CFG_SCHED_REFRESH_EN
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      good_q     <= '0;
      good_vld_q <= 1'b0;
      ref_q      <= '0;
    end else begin
      good_q     <= good_d;
      good_vld_q <= good_vld_d;
      ref_q      <= ref_d;
    end
  end
`endif

  assign TX_START  = tx_start_q;
  assign TX_WORD   = word_q;
  assign BUSY      = busy_q;
  assign PENDING   = pend_q;
  assign CFG_ERROR = err_q;
  assign SENT_CNT  = sent_q;

endmodule

// File: tb/tb_config_scheduler.sv
// tb/tb_config_scheduler.sv - self-checking bench for config_scheduler
module tb_config_scheduler;

  localparam int T   = 4096;
  localparam int LAT = 4;

  logic        CLOCK;
  logic        RESET;
  logic        HOST_WR;
  logic [23:0] HOST_DATA;
  logic        CONFIG_EN;
  logic        TX_END;
  logic        TX_START;
  logic [23:0] TX_WORD;
  logic        BUSY;
  logic        PENDING;
  logic        CFG_ERROR;
  logic [7:0]  SENT_CNT;

  int checks;
  int errors;
  int sent_exp;

  typedef struct {
    int          nwr;
    logic [23:0] w0;
    logic [23:0] w1;
    int          delay;
    logic        exp_start;
    logic [23:0] exp_word;
  } vec_t;

  vec_t        tbl[5];
  logic        pend_v;
  logic [23:0] pend_w;
  logic [23:0] w;
  logic [23:0] launched;
  int          nw;

  config_scheduler dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .HOST_WR   (HOST_WR),
    .HOST_DATA (HOST_DATA),
    .CONFIG_EN (CONFIG_EN),
    .TX_END    (TX_END),
    .TX_START  (TX_START),
    .TX_WORD   (TX_WORD),
    .BUSY      (BUSY),
    .PENDING   (PENDING),
    .CFG_ERROR (CFG_ERROR),
    .SENT_CNT  (SENT_CNT)
  );

  initial CLOCK = 1'b0;
  always #10 CLOCK = ~CLOCK;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [23:0] d);
    HOST_WR   = 1'b1;
    HOST_DATA = d;
    step();
    HOST_WR   = 1'b0;
  endtask

  // Raises CONFIG_EN for 4 cycles and watches 8 cycles for launch pulses.
  task automatic open_window(output int lat, output int nstart, output logic busy_at);
    lat     = 0;
    nstart  = 0;
    busy_at = 1'b0;
    CONFIG_EN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 4) CONFIG_EN = 1'b0;
      if (TX_START) begin
        nstart++;
        if (lat == 0) begin
          lat     = i;
          busy_at = BUSY;
        end
      end
    end
  endtask

  task automatic expect_launch(input string name, input logic [23:0] word);
    int   lat;
    int   n;
    logic b;
    open_window(lat, n, b);
    check({name, "_latency"}, lat, LAT);
    check({name, "_one_pulse"}, n, 1);
    check({name, "_busy_with_start"}, b, 1);
    check({name, "_word"}, TX_WORD, word);
  endtask

  task automatic expect_no_launch(input string name);
    int   lat;
    int   n;
    logic b;
    open_window(lat, n, b);
    check({name, "_no_start"}, n, 0);
  endtask

  task automatic finish_tx(input string name, input int delay);
    repeat (delay - 1) step();
    check({name, "_busy_hold"}, BUSY, 1);
    TX_END = 1'b1;
    step();
    TX_END = 1'b0;
    sent_exp++;
    check({name, "_busy_fell"}, BUSY, 0);
    check({name, "_sent"}, SENT_CNT, sent_exp % 256);
  endtask

  // Called right after expect_launch; ends in the first cycle after expiry.
  task automatic wait_timeout(input string name);
    repeat (T - (8 - LAT)) step();
    check({name, "_busy_last"}, BUSY, 1);
    step();
    check({name, "_busy_expired"}, BUSY, 0);
  endtask

  initial begin
    int   lat;
    int   n;
    logic b;

    checks   = 0;
    errors   = 0;
    sent_exp = 0;
    pend_v   = 1'b0;
    pend_w   = '0;

    tbl[0] = '{1, 24'hAEC9EC, 24'h000000, 500, 1'b1, 24'hAEC9EC};
    tbl[1] = '{0, 24'h000000, 24'h000000, 1,   1'b0, 24'h000000};
    tbl[2] = '{0, 24'h000000, 24'h000000, 1,   1'b0, 24'h000000};
    tbl[3] = '{2, 24'h111111, 24'h222222, 7,   1'b1, 24'h222222};
    tbl[4] = '{1, 24'hABCDEF, 24'h000000, 1,   1'b1, 24'hABCDEF};

    RESET     = 1'b1;
    HOST_WR   = 1'b0;
    HOST_DATA = '0;
    CONFIG_EN = 1'b0;
    TX_END    = 1'b0;
    step();
    step();
    check("rst_tx_start", TX_START, 0);
    check("rst_tx_word", TX_WORD, 0);
    check("rst_busy", BUSY, 0);
    check("rst_pending", PENDING, 0);
    check("rst_cfg_error", CFG_ERROR, 0);
    check("rst_sent_cnt", SENT_CNT, 0);
    RESET = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].nwr > 0) write_word(tbl[i].w0);
      if (tbl[i].nwr > 1) write_word(tbl[i].w1);
      check("tbl_pending_before", PENDING, (tbl[i].nwr > 0) ? 1 : 0);
      open_window(lat, n, b);
      check("tbl_start_count", n, tbl[i].exp_start ? 1 : 0);
      if (tbl[i].exp_start) begin
        check("tbl_latency", lat, LAT);
        check("tbl_word", TX_WORD, tbl[i].exp_word);
        check("tbl_pending_after", PENDING, 0);
        finish_tx("tbl", tbl[i].delay);
      end
    end

    // Write landing on the same edge as the window pulse is launched directly.
    CONFIG_EN = 1'b1;
    repeat (LAT - 1) step();
    HOST_WR   = 1'b1;
    HOST_DATA = 24'h5A5A5A;
    step();
    HOST_WR = 1'b0;
    check("simul_start", TX_START, 1);
    check("simul_word", TX_WORD, 24'h5A5A5A);
    check("simul_pending", PENDING, 0);
    CONFIG_EN = 1'b0;
    repeat (4) step();
    finish_tx("simul", 4);

    write_word(24'h010203);
    expect_launch("busywr_first", 24'h010203);
    write_word(24'h0C0C0C);
    check("busywr_word_held", TX_WORD, 24'h010203);
    check("busywr_pending", PENDING, 1);
    finish_tx("busywr_first", 10);
    check("busywr_pending_kept", PENDING, 1);
    expect_launch("busywr_second", 24'h0C0C0C);
    finish_tx("busywr_second", 2);

    for (int it = 0; it < 30; it++) begin
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) begin
        w = 24'($urandom);
        write_word(w);
        pend_v = 1'b1;
        pend_w = w;
      end
      check("rnd_pending", PENDING, pend_v);
      if (pend_v) begin
        launched = pend_w;
        expect_launch("rnd", launched);
        pend_v = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          w = 24'($urandom);
          write_word(w);
          pend_v = 1'b1;
          pend_w = w;
          check("rnd_word_held", TX_WORD, launched);
        end
        finish_tx("rnd", $urandom_range(1, 60));
      end else begin
        expect_no_launch("rnd_empty");
      end
      check("rnd_pending_after", PENDING, pend_v);
      repeat ($urandom_range(0, 5)) step();
    end
    if (pend_v) begin
      expect_launch("rnd_drain", pend_w);
      finish_tx("rnd_drain", 1);
    end

    for (int k = 0; k < 256; k++) begin
      write_word(24'(k));
      expect_launch("wrap", 24'(k));
      finish_tx("wrap", 1);
    end

    write_word(24'h5E5E5E);
    expect_launch("boundary", 24'h5E5E5E);
    repeat (T - (8 - LAT)) step();
    check("boundary_busy", BUSY, 1);
    TX_END = 1'b1;
    step();
    TX_END = 1'b0;
    sent_exp++;
    check("boundary_busy_fell", BUSY, 0);
    check("boundary_sent", SENT_CNT, sent_exp % 256);
    check("boundary_no_error", CFG_ERROR, 0);
    expect_no_launch("boundary_idle");

    write_word(24'h777777);
    expect_launch("retry_first", 24'h777777);
    wait_timeout("retry_first");
    step();
    check("retry_no_error_yet", CFG_ERROR, 0);
    for (int r = 0; r < 3; r++) begin
      expect_launch("retry", 24'h777777);
      wait_timeout("retry");
    end
    step();
    check("retry_cfg_error", CFG_ERROR, 1);
    check("retry_pending", PENDING, 0);
    check("retry_sent_unchanged", SENT_CNT, sent_exp % 256);
    expect_no_launch("retry_dropped");
    write_word(24'h888888);
    check("retry_error_cleared", CFG_ERROR, 0);
    check("retry_new_pending", PENDING, 1);
    expect_launch("retry_new", 24'h888888);
    finish_tx("retry_new", 3);

    write_word(24'h3C3C3C);
    expect_launch("armed", 24'h3C3C3C);
    wait_timeout("armed");
    repeat (2) step();
    write_word(24'h4D4D4D);
    check("armed_no_error", CFG_ERROR, 0);
    check("armed_pending", PENDING, 1);
    expect_launch("armed_new", 24'h4D4D4D);
    finish_tx("armed_new", 2);

`ifdef CFG_SCHED_REFRESH_EN
    write_word(24'h13579B);
    expect_launch("refresh_seed", 24'h13579B);
    finish_tx("refresh_seed", 5);
    for (int k = 0; k < 15; k++) expect_no_launch("refresh_wait");
    expect_launch("refresh_resend", 24'h13579B);
    finish_tx("refresh_resend", 5);
`endif

    write_word(24'h246810);
    expect_launch("reset_mid", 24'h246810);
    repeat (20) step();
    write_word(24'h999999);
    check("reset_mid_pending_before", PENDING, 1);
    RESET = 1'b1;
    #2;
    sent_exp = 0;
    check("reset_mid_tx_start", TX_START, 0);
    check("reset_mid_tx_word", TX_WORD, 0);
    check("reset_mid_busy", BUSY, 0);
    check("reset_mid_pending", PENDING, 0);
    check("reset_mid_cfg_error", CFG_ERROR, 0);
    check("reset_mid_sent_cnt", SENT_CNT, 0);
    step();
    RESET = 1'b0;
    step();
    expect_no_launch("reset_mid_after");
    check("reset_mid_pending_after", PENDING, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
